ram2e_dram_sched: RTL and testbench

DRAM slot scheduler for the RAM2E auxiliary-memory card. It divides each Apple II bus cycle into a PHI1 slot and a PHI0 slot, and grants each slot to video fetch, CPU access, CAS-before-RAS refresh or a new auxiliary requester. The auxiliary requester is used by the bulk-clear/self-test engine. The block drives nRAS/nCAS/nRWE and the DRAM address lines, and replaces the fixed refresh-skip sequencing with arbitrated access.

---
 rtl/ram2e_pkg.sv | 27 ++
 rtl/ram2e_refresh_ctr.sv | 44 ++++
 rtl/ram2e_dram_sched.sv | 175 +++++++++++++++++
 tb/tb_ram2e_dram_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2e_pkg.sv
// Shared constants for the RAM2E DRAM slot scheduler: grant codes,
// slot-time positions and slot base values of the cycle counter.
package ram2e_pkg;

    localparam logic [1:0] GR_IDLE  = 2'd0;
    localparam logic [1:0] GR_APPLE = 2'd1;
    localparam logic [1:0] GR_REF   = 2'd2;
    localparam logic [1:0] GR_AUX   = 2'd3;

    localparam logic [2:0] T_ROW   = 3'd0;
    localparam logic [2:0] T_RAS   = 3'd1;
    localparam logic [2:0] T_COL   = 3'd2;
    localparam logic [2:0] T_CAS   = 3'd3;
    localparam logic [2:0] T_LATCH = 3'd4;
    localparam logic [2:0] T_END   = 3'd5;

    localparam logic [3:0] S_PHI1 = 4'd1;
    localparam logic [3:0] S_PHI0 = 4'd8;
    localparam logic [3:0] S_IDLE = 4'd15;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_PHI1,
        SLOT_PHI0
    } slot_e;

endpackage

// File: rtl/ram2e_refresh_ctr.sv
// Refresh bookkeeping: divides Apple cycles into refresh ticks and keeps a
// saturating count of refreshes owed to the DRAM.
module ram2e_refresh_ctr #(
    parameter int REF_DIV    = 13,
    parameter int REF_URGENT = 4,
    parameter int DEBT_MAX   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic dec,
    output logic urgent,
    output logic pending
);

    localparam int DIVW = $clog2(REF_DIV);
    localparam int DW   = $clog2(DEBT_MAX + 1);

    logic [DIVW-1:0] div;
    logic [DW-1:0]   debt;
    logic            inc;

    assign inc     = tick && (div == DIVW'(REF_DIV - 1));
    assign urgent  = (debt >= DW'(REF_URGENT));
    assign pending = (debt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            debt <= '0;
        end else begin
            if (tick) begin
                div <= inc ? '0 : div + 1'b1;
            end
            // A simultaneous tick and completed refresh cancel out.
            if (inc && !dec && debt != DW'(DEBT_MAX)) begin
                debt <= debt + 1'b1;
            end else if (dec && !inc && debt != '0) begin
                debt <= debt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram2e_dram_sched.sv
// Slot scheduler: splits each Apple cycle into PHI1/PHI0 DRAM slots and
// grants each to video/CPU, refresh or the aux engine, driving the strobes.
module ram2e_dram_sched
    import ram2e_pkg::*;
#(
    parameter int REF_DIV    = 13,
    parameter int REF_URGENT = 4,
    parameter int DEBT_MAX   = 7
) (
    input  logic        C14M,
    input  logic        RST,
    input  logic        PHI1,
    input  logic        EN80,
    input  logic        nWE80,
    input  logic        VidEN,
    input  logic [4:0]  BA,
    input  logic        AuxReq,
    input  logic        AuxWE,
    input  logic [20:0] AuxAddr,
    input  logic [7:0]  AuxWD,
    output logic        AuxAck,
    output logic [7:0]  AuxRD,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nRWE,
    output logic [10:0] DA,
    output logic        DASel,
    output logic        RDOE,
    input  logic [7:0]  RDin,
    output logic [1:0]  Grant
);

    logic [3:0]  s;
    logic        phi1_q;
    logic        res_edge;
    slot_e       slot;
    logic [2:0]  t;
    logic [1:0]  arb;
    logic        slot_we;
    logic [10:0] col_q;
    logic        urgent;
    logic        pending;
    logic        ref_dec;

    // AuxWD reaches the data bus through the board buffer enabled by RDOE.
    logic unused_wd;
    assign unused_wd = &{1'b0, AuxWD};

    // phi1_q resets high so the first edge counts only after PHI1 was seen low.
    assign res_edge = PHI1 && !phi1_q;

    always_comb begin
        slot = SLOT_NONE;
        t    = T_ROW;
        if (s >= S_PHI1 && s < S_PHI0) begin
            slot = SLOT_PHI1;
            t    = 3'(s - S_PHI1);
        end else if (s >= S_PHI0 && s < S_IDLE) begin
            slot = SLOT_PHI0;
            t    = 3'(s - S_PHI0);
        end
    end

    always_comb begin
        arb = GR_IDLE;
        if ((slot == SLOT_PHI1) ? VidEN : EN80) arb = GR_APPLE;
        else if (urgent)                        arb = GR_REF;
        else if (AuxReq)                        arb = GR_AUX;
        else if (pending)                       arb = GR_REF;
    end

    assign ref_dec = (slot != SLOT_NONE) && (t == T_END) && (Grant == GR_REF) && !res_edge;

    ram2e_refresh_ctr #(
        .REF_DIV   (REF_DIV),
        .REF_URGENT(REF_URGENT),
        .DEBT_MAX  (DEBT_MAX)
    ) u_ref (
        .clk    (C14M),
        .rst    (RST),
        .tick   (res_edge),
        .dec    (ref_dec),
        .urgent (urgent),
        .pending(pending)
    );

    always_ff @(posedge C14M) begin
        if (RST) begin
            s       <= '0;
            phi1_q  <= 1'b1;
            nRAS    <= 1'b1;
            nCAS    <= 1'b1;
            nRWE    <= 1'b1;
            RDOE    <= 1'b0;
            DASel   <= 1'b0;
            DA      <= '0;
            AuxAck  <= 1'b0;
            AuxRD   <= '0;
            Grant   <= GR_IDLE;
            slot_we <= 1'b0;
            col_q   <= '0;
        end else begin
            phi1_q <= PHI1;
            if (res_edge)                    s <= S_PHI1;
            else if (s != '0 && s != S_IDLE) s <= s + 4'd1;

            AuxAck <= 1'b0;
            if (res_edge) begin
                // Resync: abandon whatever slot is in flight, no ack, no debt credit.
                nRAS  <= 1'b1;
                nCAS  <= 1'b1;
                nRWE  <= 1'b1;
                RDOE  <= 1'b0;
                Grant <= GR_IDLE;
            end else if (slot != SLOT_NONE) begin
                case (t)
                    T_ROW: begin
                        Grant   <= arb;
                        slot_we <= 1'b0;
                        case (arb)
                            GR_APPLE: begin
                                DASel   <= 1'b0;
                                DA      <= {BA[4:2], 8'h00};
                                col_q   <= {1'b0, BA[1:0], 8'h00};
                                slot_we <= (slot == SLOT_PHI0) && !nWE80;
                            end
                            GR_AUX: begin
                                DASel   <= 1'b1;
                                DA      <= AuxAddr[20:10];
                                col_q   <= {1'b0, AuxAddr[9:0]};
                                slot_we <= AuxWE;
                            end
                            GR_REF: begin
                                DASel <= 1'b0;
                                DA    <= '0;
                            end
                            default: ;
                        endcase
                    end
                    T_RAS: begin
                        if (Grant == GR_REF)       nCAS <= 1'b0;
                        else if (Grant != GR_IDLE) nRAS <= 1'b0;
                    end
                    T_COL: begin
                        if (Grant == GR_REF) begin
                            nRAS <= 1'b0;
                        end else if (Grant != GR_IDLE) begin
                            DA <= col_q;
                            if (slot_we) begin
                                nRWE <= 1'b0;
                                RDOE <= (Grant == GR_AUX);
                            end
                        end
                    end
                    T_CAS: begin
                        if (Grant == GR_APPLE || Grant == GR_AUX) nCAS <= 1'b0;
                    end
                    T_LATCH: begin
                        // Only aux reads own the read-back register.
                        if (Grant == GR_AUX && !slot_we) AuxRD <= RDin;
                    end
                    T_END: begin
                        nRAS   <= 1'b1;
                        nCAS   <= 1'b1;
                        nRWE   <= 1'b1;
                        RDOE   <= 1'b0;
                        AuxAck <= (Grant == GR_AUX);
                    end
                    default: Grant <= GR_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram2e_dram_sched.sv
// Directed bench for the RAM2E DRAM slot scheduler: per-cycle grant table
// plus hand sequences for write/read, resync abort, stretch and saturation.
module tb_ram2e_dram_sched;

    logic        C14M = 1'b0;
    logic        RST;
    logic        PHI1;
    logic        EN80;
    logic        nWE80;
    logic        VidEN;
    logic [4:0]  BA;
    logic        AuxReq;
    logic        AuxWE;
    logic [20:0] AuxAddr;
    logic [7:0]  AuxWD;
    logic        AuxAck;
    logic [7:0]  AuxRD;
    logic        nRAS;
    logic        nCAS;
    logic        nRWE;
    logic [10:0] DA;
    logic        DASel;
    logic        RDOE;
    logic [7:0]  RDin;
    logic [1:0]  Grant;

    int checks = 0;
    int errors = 0;

    ram2e_dram_sched dut (
        .C14M   (C14M),
        .RST    (RST),
        .PHI1   (PHI1),
        .EN80   (EN80),
        .nWE80  (nWE80),
        .VidEN  (VidEN),
        .BA     (BA),
        .AuxReq (AuxReq),
        .AuxWE  (AuxWE),
        .AuxAddr(AuxAddr),
        .AuxWD  (AuxWD),
        .AuxAck (AuxAck),
        .AuxRD  (AuxRD),
        .nRAS   (nRAS),
        .nCAS   (nCAS),
        .nRWE   (nRWE),
        .DA     (DA),
        .DASel  (DASel),
        .RDOE   (RDOE),
        .RDin   (RDin),
        .Grant  (Grant)
    );

    always #35 C14M = ~C14M;

    // One-byte DRAM model: latches on an early write, drives only while CAS is low.
    logic [7:0] dram_q = 8'h00;
    assign RDin = nCAS ? 8'hFF : dram_q;
    always @(negedge C14M) begin
        if (!nCAS && !nRWE && RDOE) dram_q <= AuxWD;
    end

    // Per-clock samples of one Apple cycle; index k holds S=k for k>=1.
    logic [1:0]  sg[16];
    logic        sras[16];
    logic        scas[16];
    logic        srwe[16];
    logic        srdoe[16];
    logic        sack[16];
    logic        sdasel[16];
    logic [10:0] sda[16];
    logic [7:0]  srd[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apple_cycle(input int len, input bit drop_on_ack);
        int hi;
        hi = (len >= 9) ? 7 : 2;
        for (int k = 0; k < len; k++) begin
            @(negedge C14M);
            sg[k]     = Grant;
            sras[k]   = nRAS;
            scas[k]   = nCAS;
            srwe[k]   = nRWE;
            srdoe[k]  = RDOE;
            sack[k]   = AuxAck;
            sdasel[k] = DASel;
            sda[k]    = DA;
            srd[k]    = AuxRD;
            if (drop_on_ack && AuxAck) AuxReq = 1'b0;
            PHI1 = (k < hi);
        end
    endtask

    typedef struct {
        int         rep;
        logic       vid;
        logic       en80;
        logic       areq;
        logic [1:0] g1;
        logic [1:0] g0;
    } vec_t;

    vec_t vecs[10];
    int   acks;

    initial begin
        // Cycle numbers in the notes count qualified PHI1 edges from reset.
        vecs[0] = '{12, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // 1-12: no debt yet
        vecs[1] = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 2'd0}; // 13: first tick, one refresh
        vecs[2] = '{51, 1'b0, 1'b1, 1'b1, 2'd3, 2'd1}; // 14-64: aux in PHI1, CPU in PHI0
        vecs[3] = '{1,  1'b0, 1'b1, 1'b1, 2'd2, 2'd1}; // 65: debt hits 4, refresh beats aux
        vecs[4] = '{2,  1'b0, 1'b1, 1'b1, 2'd3, 2'd1}; // 66-67: debt 3, aux again
        vecs[5] = '{2,  1'b1, 1'b0, 1'b1, 2'd1, 2'd3}; // 68-69: video PHI1, aux PHI0
        vecs[6] = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 2'd2}; // 70: drain 3 -> 1
        vecs[7] = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 2'd0}; // 71: drain 1 -> 0
        vecs[8] = '{6,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // 72-77
        vecs[9] = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 2'd0}; // 78: tick, refresh

        RST = 1'b1; PHI1 = 1'b0; EN80 = 1'b0; nWE80 = 1'b1; VidEN = 1'b0;
        BA = 5'b10110; AuxReq = 1'b0; AuxWE = 1'b0; AuxAddr = '0; AuxWD = '0;
        repeat (3) @(negedge C14M);
        chk("rst_nras", nRAS, 1);
        chk("rst_ncas", nCAS, 1);
        chk("rst_nrwe", nRWE, 1);
        chk("rst_rdoe", RDOE, 0);
        chk("rst_dasel", DASel, 0);
        chk("rst_da", DA, 0);
        chk("rst_ack", AuxAck, 0);
        chk("rst_rd", AuxRD, 0);
        chk("rst_grant", Grant, 0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                VidEN  = vecs[i].vid;
                EN80   = vecs[i].en80;
                AuxReq = vecs[i].areq;
                AuxWE  = 1'b0;
                apple_cycle(14, 1'b0);
                chk($sformatf("v%0d.%0d grant_phi1", i, r), sg[2], vecs[i].g1);
                chk($sformatf("v%0d.%0d grant_phi0", i, r), sg[9], vecs[i].g0);
                if (vecs[i].g1 == 2'd2) begin
                    chk($sformatf("v%0d.%0d ref_cas_t1", i, r), scas[3], 0);
                    chk($sformatf("v%0d.%0d ref_ras_t1", i, r), sras[3], 1);
                    chk($sformatf("v%0d.%0d ref_ras_t2", i, r), sras[4], 0);
                    chk($sformatf("v%0d.%0d ref_rwe", i, r), srwe[5], 1);
                end
                if (vecs[i].g1 == 2'd3) chk($sformatf("v%0d.%0d aux_ack", i, r), sack[7], 1);
                if (vecs[i].g1 == 2'd1) begin
                    chk($sformatf("v%0d.%0d vid_dasel", i, r), sdasel[2], 0);
                    chk($sformatf("v%0d.%0d vid_row", i, r), sda[2], 11'h500);
                    chk($sformatf("v%0d.%0d vid_col", i, r), sda[4], 11'h200);
                end
            end
        end

        // Aux write of 0xA5 to row 0x2AA, column 0x1AA.
        AuxAddr = {11'h2AA, 10'h1AA}; AuxWD = 8'hA5; AuxWE = 1'b1; AuxReq = 1'b1;
        apple_cycle(14, 1'b1);
        chk("wr_grant", sg[2], 3);
        chk("wr_dasel", sdasel[2], 1);
        chk("wr_row", sda[2], 11'h2AA);
        chk("wr_ras_t0", sras[2], 1);
        chk("wr_ras_t1", sras[3], 0);
        chk("wr_col", sda[4], 11'h1AA);
        chk("wr_rwe_t2", srwe[4], 0);
        chk("wr_rdoe_t2", srdoe[4], 1);
        chk("wr_cas_t2", scas[4], 1);
        chk("wr_cas_t3", scas[5], 0);
        chk("wr_rwe_t4", srwe[6], 0);
        chk("wr_rwe_t5", srwe[7], 1);
        chk("wr_rdoe_t5", srdoe[7], 0);
        chk("wr_ras_t5", sras[7], 1);
        chk("wr_ack", sack[7], 1);
        chk("wr_ack_once", sack[8], 0);
        chk("wr_phi0_idle", sg[9], 0);

        // Read back the same location.
        AuxWE = 1'b0; AuxReq = 1'b1;
        apple_cycle(14, 1'b1);
        chk("rd_grant", sg[2], 3);
        chk("rd_rwe", srwe[4], 1);
        chk("rd_rdoe", srdoe[4], 0);
        chk("rd_ack", sack[7], 1);
        chk("rd_data", srd[7], 8'hA5);

        // Write aborted by a PHI1 edge at S5, retried in the next slot.
        AuxAddr = {11'h001, 10'h3FF}; AuxWD = 8'h3C; AuxWE = 1'b1; AuxReq = 1'b1;
        apple_cycle(5, 1'b1);
        acks = 0;
        for (int k = 1; k < 5; k++) acks += int'(sack[k]);
        chk("ab_grant", sg[2], 3);
        chk("ab_ras_t1", sras[3], 0);
        chk("ab_rwe_t2", srwe[4], 0);
        apple_cycle(14, 1'b1);
        for (int k = 0; k < 7; k++) acks += int'(sack[k]);
        chk("ab_cas_before", scas[0], 0);
        chk("ab_ras_after", sras[1], 1);
        chk("ab_cas_after", scas[1], 1);
        chk("ab_rwe_after", srwe[1], 1);
        chk("ab_rdoe_after", srdoe[1], 0);
        chk("ab_grant_after", sg[1], 0);
        chk("ab_no_ack", acks, 0);
        chk("ab_retry_grant", sg[2], 3);
        chk("ab_retry_row", sda[2], 11'h001);
        chk("ab_retry_ack", sack[7], 1);

        // Stretched 16-clock cycle with aux reads in both slots.
        AuxWE = 1'b0; AuxReq = 1'b1;
        apple_cycle(16, 1'b0);
        chk("st_phi0_grant", sg[9], 3);
        chk("st_phi0_ack", sack[14], 1);
        chk("st_s15_ack", sack[15], 0);
        chk("st_s15_grant", sg[15], 0);
        chk("st_s15_ras", sras[15], 1);
        chk("st_s15_cas", scas[15], 1);
        apple_cycle(14, 1'b0);
        chk("st_s15b_grant", sg[0], 0);
        chk("st_s15b_ras", sras[0], 1);
        chk("st_s1_ras", sras[1], 1);
        chk("st_next_grant", sg[2], 3);
        chk("st_next_ras", sras[3], 0);

        // Every slot busy long enough for eight ticks: debt must stop at 7.
        AuxReq = 1'b0; VidEN = 1'b1; EN80 = 1'b1;
        repeat (100) apple_cycle(14, 1'b0);
        chk("sat_grant_phi1", sg[2], 1);
        chk("sat_grant_phi0", sg[9], 1);
        chk("sat_debt", 32'(dut.u_ref.debt), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
